// File: rtl/program_loader_if.sv
// -----------------------------------------------------------------------------
// program_loader_if
//
// Groups the loader's two streams: the incoming byte stream (typically a UART
// receiver) and the outgoing write port into the instruction memory.
//
//   RX_DATA  [7:0]         received byte, meaningful only while RX_DONE=1
//   RX_DONE                one-cycle strobe per received byte
//   WR_EN                  one-cycle write strobe to program memory
//   WR_ADDR  [ADDR_W-1:0]  write address
//   WR_DATA  [15:0]        instruction word to write
//
// master: the loader (consumes bytes, drives the write port)
// slave : the environment (produces bytes, observes the write port)
// -----------------------------------------------------------------------------
interface program_loader_if #(
    parameter int ADDR_W = 11
);
    logic [7:0]        RX_DATA;
    logic              RX_DONE;
    logic              WR_EN;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [15:0]       WR_DATA;

    modport master (
        input  RX_DATA,
        input  RX_DONE,
        output WR_EN,
        output WR_ADDR,
        output WR_DATA
    );

    modport slave (
        output RX_DATA,
        output RX_DONE,
        input  WR_EN,
        input  WR_ADDR,
        input  WR_DATA
    );
endinterface

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Assembles a byte stream (high byte first) into 16-bit BIP instruction words
// and writes them to program memory at consecutive addresses starting at 0.
// Loading ends after a HLT word (16'h0000) or once the last address has been
// written; LOAD_DONE then stays high until START or RESET re-arms the loader.
//
// Ports:
//   CLK         clock, all logic on the rising edge
//   RESET       synchronous active-high reset, highest priority
//   START       one-cycle pulse re-arming the loader for a new program
//   bus         program_loader_if.master (RX byte stream in, write port out)
//   BUSY        a word is partially assembled or being written
//   LOAD_DONE   program fully loaded (level)
//   WORD_COUNT  words written since the loader was last armed
//   ERR         sticky: a byte arrived while it could not be accepted
//
// Every output is a flop; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
    program_loader_if.master    bus,
    output logic                BUSY,
    output logic                LOAD_DONE,
    output logic [ADDR_W:0]     WORD_COUNT,
    output logic                ERR
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        WAIT_HI,
        WAIT_LO,
        WRITE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [15:0]       data_q, data_d;
    logic              err_q, err_d;
    logic              wr_en_q;
    logic              busy_q;
    logic              done_q;

    // Next-state and next-value logic.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;

        if (START) begin
            // Re-arm. A byte strobed in the same cycle is discarded silently,
            // and a write already in flight still pulses WR_EN but is not
            // counted, because the counter is cleared here instead.
            state_d = WAIT_HI;
            hi_d    = '0;
            addr_d  = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                WAIT_HI: begin
                    if (bus.RX_DONE) begin
                        hi_d    = bus.RX_DATA;
                        state_d = WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (bus.RX_DONE) begin
                        data_d  = {hi_q, bus.RX_DATA};
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    cnt_d = cnt_q + (ADDR_W + 1)'(1);
                    // No byte can be accepted while the word is being written.
                    if (bus.RX_DONE) begin
                        err_d = 1'b1;
                    end
                    // Stop on HLT or on the last address; the address counter
                    // is left on the final word rather than wrapping.
                    if (data_q == 16'h0000 || addr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = WAIT_HI;
                    end
                end
                DONE: begin
                    if (bus.RX_DONE) begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = WAIT_HI;
            endcase
        end
    end

    // State and output registers. The status outputs are decoded from the
    // next state so they line up with the state they describe.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments make every flop sample the values from
        // before this edge, independent of statement order.
        if (RESET) begin
            state_q <= WAIT_HI;
            hi_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            wr_en_q <= (state_d == WRITE);
            busy_q  <= (state_d == WAIT_LO) || (state_d == WRITE);
            done_q  <= (state_d == DONE);
        end
    end

    // The address counter doubles as WR_ADDR: it is stable for the whole
    // WRITE cycle and parks on the last address once loading is done.
    assign bus.WR_EN   = wr_en_q;
    assign bus.WR_ADDR = addr_q;
    assign bus.WR_DATA = data_q;
    assign BUSY        = busy_q;
    assign LOAD_DONE   = done_q;
    assign WORD_COUNT  = cnt_q;
    assign ERR         = err_q;

endmodule
